dmi_jtag_dtm: RTL and testbench

JTAG Debug Transport Module, sitting directly upstream of the DMI tap/pass-through stage. It oversamples a JTAG port in the system clock domain, runs the IEEE 1149.1 TAP state machine, implements the RISC-V Debug Spec 0.13 IDCODE/DTMCS/DMI/BYPASS registers, and issues DMI requests and collects DMI responses. It allows at most one outstanding DMI request at a time.

---
 rtl/dmi_jtag_dtm.sv | 189 ++++++++++++++++++
 tb/tb_dmi_jtag_dtm.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_jtag_dtm.sv
// JTAG DTM (RISC-V Debug 0.13): oversampled TAP, IDCODE/DTMCS/DMI/BYPASS, one outstanding DMI request.
// Optional DTMCS.dmihardreset support is enabled by defining DTM_DMIHARDRESET_EN.
module dmi_jtag_dtm #(
  parameter logic [31:0] IDCODE = 32'h1000_0913,
  parameter int          ABITS  = 7
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             jtag_tck,
  input  logic             jtag_tms,
  input  logic             jtag_tdi,
  output logic             jtag_tdo,
  output logic             dmi_req_valid,
  input  logic             dmi_req_ready,
  output logic [ABITS-1:0] dmi_req_bits_addr,
  output logic [1:0]       dmi_req_bits_op,
  output logic [31:0]      dmi_req_bits_data,
  input  logic             dmi_resp_valid,
  output logic             dmi_resp_ready,
  input  logic [1:0]       dmi_resp_bits_resp,
  input  logic [31:0]      dmi_resp_bits_data
);
  localparam int DR_W = ABITS + 34;

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UP_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UP_IR
  } tap_e;

  logic [1:0] tck_sync, tms_sync, tdi_sync;
  logic       tck_q;
  logic       tck_rise, tck_fall, tms, tdi;
  tap_e       state;
  logic [4:0] ir, ir_sr;
  logic [DR_W-1:0] dr;
  logic [1:0] sticky;
  logic       busy;
  logic [31:0] resp_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
      tck_q    <= 1'b0;
    end else begin
      tck_sync <= {tck_sync[0], jtag_tck};
      tms_sync <= {tms_sync[0], jtag_tms};
      tdi_sync <= {tdi_sync[0], jtag_tdi};
      tck_q    <= tck_sync[1];
    end
  end

  assign tck_rise = tck_sync[1] & ~tck_q;
  assign tck_fall = ~tck_sync[1] & tck_q;
  assign tms      = tms_sync[1];
  assign tdi      = tdi_sync[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= TLR;
    else if (tck_rise) begin
      case (state)
        TLR:     state <= tms ? TLR    : RTI;
        RTI:     state <= tms ? SEL_DR : RTI;
        SEL_DR:  state <= tms ? SEL_IR : CAP_DR;
        CAP_DR:  state <= tms ? EX1_DR : SH_DR;
        SH_DR:   state <= tms ? EX1_DR : SH_DR;
        EX1_DR:  state <= tms ? UP_DR  : PA_DR;
        PA_DR:   state <= tms ? EX2_DR : PA_DR;
        EX2_DR:  state <= tms ? UP_DR  : SH_DR;
        UP_DR:   state <= tms ? SEL_DR : RTI;
        SEL_IR:  state <= tms ? TLR    : CAP_IR;
        CAP_IR:  state <= tms ? EX1_IR : SH_IR;
        SH_IR:   state <= tms ? EX1_IR : SH_IR;
        EX1_IR:  state <= tms ? UP_IR  : PA_IR;
        PA_IR:   state <= tms ? EX2_IR : PA_IR;
        EX2_IR:  state <= tms ? UP_IR  : SH_IR;
        UP_IR:   state <= tms ? SEL_DR : RTI;
        default: state <= TLR;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ir    <= 5'h01;
      ir_sr <= 5'h01;
    end else if (state == TLR) begin
      ir <= 5'h01;
    end else if (tck_rise) begin
      case (state)
        CAP_IR:  ir_sr <= 5'b00001;
        SH_IR:   ir_sr <= {tdi, ir_sr[4:1]};
        UP_IR:   ir    <= ir_sr;
        default: ;
      endcase
    end
  end

  logic is_idcode, is_dtmcs, is_dmi;
  assign is_idcode = (ir == 5'h01);
  assign is_dtmcs  = (ir == 5'h10);
  assign is_dmi    = (ir == 5'h11);

  // A response accepted this cycle is visible to a coincident Capture/Update.
  logic        resp_fire, resp_err, busy_eff;
  logic [1:0]  sticky_eff;
  logic [31:0] data_eff, dtmcs_val;
  assign resp_fire  = dmi_resp_valid & dmi_resp_ready;
  assign resp_err   = resp_fire && (dmi_resp_bits_resp == 2'd2) && (sticky == 2'd0);
  assign busy_eff   = busy & ~resp_fire;
  assign sticky_eff = resp_err ? 2'd2 : sticky;
  assign data_eff   = resp_fire ? dmi_resp_bits_data : resp_data;
  assign dtmcs_val  = {14'b0, 2'b0, 1'b0, 3'd1, sticky_eff, 6'(ABITS), 4'd1};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) dr <= '0;
    else if (tck_rise) begin
      if (state == CAP_DR) begin
        if (is_idcode)     dr <= DR_W'(IDCODE);
        else if (is_dtmcs) dr <= DR_W'(dtmcs_val);
        else if (is_dmi)   dr <= {dmi_req_bits_addr, data_eff, busy_eff ? 2'd3 : sticky_eff};
        else               dr <= '0;
      end else if (state == SH_DR) begin
        if (is_idcode || is_dtmcs) dr <= DR_W'({tdi, dr[31:1]});
        else if (is_dmi)           dr <= {tdi, dr[DR_W-1:1]};
        else                       dr <= DR_W'(tdi);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) jtag_tdo <= 1'b0;
    else if (tck_fall) begin
      if (state == SH_DR)      jtag_tdo <= dr[0];
      else if (state == SH_IR) jtag_tdo <= ir_sr[0];
      else                     jtag_tdo <= 1'b0;
    end
  end

  // Later assignments win: JTAG-side updates override the handshake bookkeeping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dmi_req_valid     <= 1'b0;
      dmi_resp_ready    <= 1'b0;
      dmi_req_bits_addr <= '0;
      dmi_req_bits_op   <= '0;
      dmi_req_bits_data <= '0;
      busy              <= 1'b0;
      sticky            <= 2'd0;
      resp_data         <= '0;
    end else begin
      if (dmi_req_valid && dmi_req_ready) begin
        dmi_req_valid  <= 1'b0;
        dmi_resp_ready <= 1'b1;
      end
      if (resp_fire) begin
        resp_data      <= dmi_resp_bits_data;
        busy           <= 1'b0;
        dmi_resp_ready <= 1'b0;
        if (resp_err) sticky <= 2'd2;
      end
      if (tck_rise && state == CAP_DR && is_dmi && busy_eff) sticky <= 2'd3;
      if (tck_rise && state == UP_DR) begin
        if (is_dmi) begin
          if (busy_eff) sticky <= 2'd3;
          else if (sticky_eff == 2'd0 && (dr[1:0] == 2'd1 || dr[1:0] == 2'd2)) begin
            dmi_req_bits_addr <= dr[DR_W-1 -: ABITS];
            dmi_req_bits_data <= dr[33:2];
            dmi_req_bits_op   <= dr[1:0];
            dmi_req_valid     <= 1'b1;
            busy              <= 1'b1;
          end
        end
        if (is_dtmcs) begin
          if (dr[16]) sticky <= 2'd0;
`ifdef DTM_DMIHARDRESET_EN
          if (dr[17]) begin
            dmi_req_valid  <= 1'b0;
            dmi_resp_ready <= 1'b0;
            busy           <= 1'b0;
            sticky         <= 2'd0;
          end
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_dmi_jtag_dtm.sv
// Directed bench for dmi_jtag_dtm: table of JTAG scans plus DMI handshake sequences.
module tb_dmi_jtag_dtm;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;
  logic        dmi_req_valid, dmi_req_ready;
  logic [6:0]  dmi_req_bits_addr;
  logic [1:0]  dmi_req_bits_op;
  logic [31:0] dmi_req_bits_data;
  logic        dmi_resp_valid, dmi_resp_ready;
  logic [1:0]  dmi_resp_bits_resp;
  logic [31:0] dmi_resp_bits_data;

  int errors = 0;
  int checks = 0;

  dmi_jtag_dtm dut (
    .clock(clock), .reset_n(reset_n),
    .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_bits_addr(dmi_req_bits_addr), .dmi_req_bits_op(dmi_req_bits_op),
    .dmi_req_bits_data(dmi_req_bits_data),
    .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready),
    .dmi_resp_bits_resp(dmi_resp_bits_resp), .dmi_resp_bits_data(dmi_resp_bits_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_ir;
    int          len;
    logic [40:0] din;
    logic [40:0] exp;
  } scan_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // One TCK period, 4 clocks low then 4 high; TDO sampled just before the rise.
  task automatic tck_pulse(input logic tms, input logic tdi, output logic tdo);
    jtag_tck = 1'b0;
    jtag_tms = tms;
    jtag_tdi = tdi;
    repeat (4) cyc();
    tdo = jtag_tdo;
    jtag_tck = 1'b1;
    repeat (4) cyc();
  endtask

  // Run-Test/Idle -> scan -> Update -> Run-Test/Idle.
  task automatic scan(input logic is_ir, input int n, input logic [40:0] din, output logic [40:0] dout);
    logic b;
    dout = '0;
    tck_pulse(1'b1, 1'b0, b);
    if (is_ir) tck_pulse(1'b1, 1'b0, b);
    tck_pulse(1'b0, 1'b0, b);
    tck_pulse(1'b0, 1'b0, b);
    for (int i = 0; i < n; i++) begin
      tck_pulse(i == n - 1, din[i], b);
      dout[i] = b;
    end
    tck_pulse(1'b1, 1'b0, b);
    tck_pulse(1'b0, 1'b0, b);
  endtask

  task automatic scan_chk(input string nm, input logic is_ir, input int n,
                          input logic [40:0] din, input logic [40:0] exp);
    logic [40:0] d;
    scan(is_ir, n, din, d);
    chk(nm, 64'(d), 64'(exp));
  endtask

  task automatic wait_req(input string nm);
    int k;
    for (k = 0; k < 64 && !dmi_req_valid; k++) cyc();
    if (!dmi_req_valid) chk({nm, " req timeout"}, 64'(0), 64'(1));
  endtask

  // Accept the pending request, then return one response.
  task automatic handshake(input string nm, input logic [1:0] rresp, input logic [31:0] rdata);
    wait_req(nm);
    dmi_req_ready = 1'b1;
    cyc();
    dmi_req_ready = 1'b0;
    chk({nm, " valid/resp_ready after accept"}, 64'({dmi_req_valid, dmi_resp_ready}), 64'(2'b01));
    dmi_resp_valid = 1'b1;
    dmi_resp_bits_resp = rresp;
    dmi_resp_bits_data = rdata;
    cyc();
    dmi_resp_valid = 1'b0;
    chk({nm, " resp_ready after resp"}, 64'(dmi_resp_ready), 64'(0));
  endtask

  function automatic logic [40:0] dmi(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    return {a, d, op};
  endfunction

  scan_t vec [9];
  logic b;
  logic [40:0] dout;

  initial begin
    vec[0] = '{1'b0, 32, 41'h0,            41'h0_1000_0913};
    vec[1] = '{1'b1, 5,  41'h10,           41'h01};
    vec[2] = '{1'b0, 32, 41'h0,            41'h0_0000_1071};
    vec[3] = '{1'b1, 5,  41'h1f,           41'h01};
    vec[4] = '{1'b0, 8,  41'hB6,           41'h6C};
    vec[5] = '{1'b1, 5,  41'h05,           41'h01};
    vec[6] = '{1'b0, 4,  41'hF,            41'hE};
    vec[7] = '{1'b1, 5,  41'h01,           41'h01};
    vec[8] = '{1'b0, 32, 41'h0_FFFF_FFFF,  41'h0_1000_0913};

    reset_n = 1'b0;
    jtag_tck = 1'b0; jtag_tms = 1'b1; jtag_tdi = 1'b0;
    dmi_req_ready = 1'b0; dmi_resp_valid = 1'b0;
    dmi_resp_bits_resp = 2'd0; dmi_resp_bits_data = '0;
    repeat (3) cyc();
    chk("reset outputs",
        64'({dmi_req_valid, dmi_resp_ready, jtag_tdo, dmi_req_bits_addr, dmi_req_bits_op, dmi_req_bits_data}),
        64'(0));
    reset_n = 1'b1;
    repeat (5) tck_pulse(1'b1, 1'b0, b);
    tck_pulse(1'b0, 1'b0, b);

    for (int i = 0; i < 9; i++) begin
      scan(vec[i].is_ir, vec[i].len, vec[i].din, dout);
      checks++;
      if (dout !== vec[i].exp) begin
        errors++;
        $display("FAIL scan vector %0d: got %h expected %h", i, dout, vec[i].exp);
      end
    end

    // DMI write held off by ready for 5 cycles
    scan_chk("ir dmi", 1'b1, 5, 41'h11, 41'h01);
    scan_chk("dmi write capture", 1'b0, 41, dmi(7'h10, 32'h1, 2'd2), 41'h0);
    for (int i = 0; i < 5; i++) begin
      chk("write held", 64'({dmi_req_valid, dmi_req_bits_addr, dmi_req_bits_data, dmi_req_bits_op}),
          64'({1'b1, 7'h10, 32'h1, 2'd2}));
      cyc();
    end
    handshake("write", 2'd0, 32'h0);

    // DMI read returns data on the next capture
    scan_chk("dmi read capture", 1'b0, 41, dmi(7'h11, 32'h0, 2'd1), dmi(7'h10, 32'h0, 2'd0));
    chk("read req bits", 64'({dmi_req_bits_addr, dmi_req_bits_op}), 64'({7'h11, 2'd1}));
    handshake("read", 2'd0, 32'hDEAD_BEEF);
    scan_chk("read data", 1'b0, 41, dmi(7'h00, 32'h0, 2'd0), dmi(7'h11, 32'hDEAD_BEEF, 2'd0));
    repeat (8) cyc();
    chk("nop issues no req", 64'(dmi_req_valid), 64'(0));

    // Busy: capture while a request is outstanding
    scan_chk("busy read capture", 1'b0, 41, dmi(7'h05, 32'h0, 2'd1), dmi(7'h11, 32'hDEAD_BEEF, 2'd0));
    wait_req("busy");
    dmi_req_ready = 1'b1;
    cyc();
    dmi_req_ready = 1'b0;
    scan_chk("busy capture op3", 1'b0, 41, dmi(7'h00, 32'h0, 2'd0), dmi(7'h05, 32'hDEAD_BEEF, 2'd3));
    scan_chk("ir dtmcs", 1'b1, 5, 41'h10, 41'h01);
    scan_chk("dtmcs dmistat=3", 1'b0, 32, 41'h0, 41'h0_0000_1C71);
    dmi_resp_valid = 1'b1; dmi_resp_bits_resp = 2'd0; dmi_resp_bits_data = 32'hCAFE_0001;
    cyc();
    dmi_resp_valid = 1'b0;
    chk("busy resp accepted", 64'(dmi_resp_ready), 64'(0));
    scan_chk("ir dmi 2", 1'b1, 5, 41'h11, 41'h01);
    scan_chk("sticky capture", 1'b0, 41, dmi(7'h20, 32'h55, 2'd2), dmi(7'h05, 32'hCAFE_0001, 2'd3));
    repeat (8) cyc();
    chk("sticky blocks req", 64'(dmi_req_valid), 64'(0));
    scan_chk("ir dtmcs 2", 1'b1, 5, 41'h10, 41'h01);
    scan_chk("dtmcs dmireset", 1'b0, 32, 41'h1_0000, 41'h0_0000_1C71);
    scan_chk("dtmcs cleared", 1'b0, 32, 41'h0, 41'h0_0000_1071);

    // Failed response sets dmistat=2
    scan_chk("ir dmi 3", 1'b1, 5, 41'h11, 41'h01);
    scan_chk("write after clear", 1'b0, 41, dmi(7'h20, 32'h55, 2'd2), dmi(7'h05, 32'hCAFE_0001, 2'd0));
    handshake("err", 2'd2, 32'h0000_0BAD);
    scan_chk("err capture", 1'b0, 41, dmi(7'h00, 32'h0, 2'd0), dmi(7'h20, 32'h0000_0BAD, 2'd2));
    scan_chk("ir dtmcs 3", 1'b1, 5, 41'h10, 41'h01);
    scan_chk("dtmcs dmistat=2", 1'b0, 32, 41'h1_0000, 41'h0_0000_1871);
    scan_chk("dtmcs cleared 2", 1'b0, 32, 41'h0, 41'h0_0000_1071);

`ifdef DTM_DMIHARDRESET_EN
    scan_chk("ir dmi hr", 1'b1, 5, 41'h11, 41'h01);
    scan_chk("hr read", 1'b0, 41, dmi(7'h07, 32'h0, 2'd1), dmi(7'h20, 32'h0000_0BAD, 2'd0));
    wait_req("hr");
    scan_chk("ir dtmcs hr", 1'b1, 5, 41'h10, 41'h01);
    scan_chk("dtmcs hardreset", 1'b0, 32, 41'h2_0000, 41'h0_0000_1071);
    chk("hardreset drops req", 64'({dmi_req_valid, dmi_resp_ready}), 64'(0));
    scan_chk("ir dmi hr2", 1'b1, 5, 41'h11, 41'h01);
    scan_chk("write after hr", 1'b0, 41, dmi(7'h08, 32'h9, 2'd2), dmi(7'h07, 32'h0000_0BAD, 2'd0));
    chk("hr new req", 64'({dmi_req_valid, dmi_req_bits_addr, dmi_req_bits_data, dmi_req_bits_op}),
        64'({1'b1, 7'h08, 32'h9, 2'd2}));
    handshake("hr write", 2'd0, 32'h0);
`endif

    // Reset in the middle of a pending request
    scan_chk("ir dmi rst", 1'b1, 5, 41'h11, 41'h01);
    scan(1'b0, 41, dmi(7'h33, 32'h77, 2'd2), dout);
    wait_req("rst");
    reset_n = 1'b0;
    #1;
    chk("async reset mid-request",
        64'({dmi_req_valid, dmi_resp_ready, jtag_tdo, dmi_req_bits_addr, dmi_req_bits_op, dmi_req_bits_data}),
        64'(0));
    cyc();
    reset_n = 1'b1;
    cyc();
    repeat (5) tck_pulse(1'b1, 1'b0, b);
    tck_pulse(1'b0, 1'b0, b);
    scan_chk("idcode after reset", 1'b0, 32, 41'h0, 41'h0_1000_0913);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
